// File: rtl/imem_refill_arbiter.sv
// Shares one main-memory port between instruction refills and data accesses.
// Round-robin on ties, one transaction at a time, with a per-transaction ack timeout.
module imem_refill_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  stallF,
  output logic                  stallM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_owner_q, last_owner_d;  // 0 = I, 1 = D
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  i_done_q, i_done_d;
  logic                  d_done_q, d_done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  grant_i_s, grant_d_s;

  // I wins a tie only when D owned the port last.
  assign grant_i_s = i_req & (~d_req | last_owner_q);
  assign grant_d_s = d_req & ~grant_i_s;

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    rdata_d      = '0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_i_s) begin
          mem_addr_d   = i_addr;
          mem_we_d     = 1'b0;
          mem_wdata_d  = '0;
          mem_req_d    = 1'b1;
          last_owner_d = 1'b0;
          cnt_d        = '0;
          state_d      = BUSY_I;
        end else if (grant_d_s) begin
          mem_addr_d   = d_addr;
          mem_we_d     = d_we;
          mem_wdata_d  = d_wdata;
          mem_req_d    = 1'b1;
          last_owner_d = 1'b1;
          cnt_d        = '0;
          state_d      = BUSY_D;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack on the last allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          rdata_d   = (state_q == BUSY_D && mem_we_q) ? '0 : mem_rdata;
          err_d     = 1'b0;
          mem_req_d = 1'b0;
          i_done_d  = (state_q == BUSY_I);
          d_done_d  = (state_q == BUSY_D);
          state_d   = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          i_done_d  = (state_q == BUSY_I);
          d_done_d  = (state_q == BUSY_D);
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign stallF    = i_req & ~i_done_q;
  assign stallM    = d_req & ~d_done_q;

endmodule

// File: tb/tb_imem_refill_arbiter.sv
// Scoreboard bench for imem_refill_arbiter: expected completions are queued
// when a request is driven and compared by a monitor when a done pulse appears.
module tb_imem_refill_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_done, d_done, err, stallF, stallM, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  typedef struct {
    logic        side;   // 0 = I, 1 = D
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_delay = 0;   // BUSY cycle in which memory acks; 0 = never
  int   busy_cnt = 0;
  logic stray = 1'b0;

  imem_refill_arbiter #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .err(err), .stallF(stallF), .stallM(stallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory responder: acks in the ack_delay-th cycle that mem_req is high.
  always @(negedge clk) begin
    if (mem_req) begin
      busy_cnt = busy_cnt + 1;
      mem_ack  = (busy_cnt == ack_delay) || stray;
    end else begin
      busy_cnt = 0;
      mem_ack  = stray;
    end
  end

  // Completion monitor; also models requesters dropping req after done.
  always @(negedge clk) begin
    if (i_done && d_done) begin
      checks++;
      errors++;
      $display("FAIL both_done: i_done=1 d_done=1, required at most one");
    end else if (i_done || d_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: i_done=%0b d_done=%0b with nothing pending", i_done, d_done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (d_done !== e.side || rdata !== e.rdata || err !== e.err) begin
          errors++;
          $display("FAIL completion: got side=%0b rdata=%h err=%0b, required side=%0b rdata=%h err=%0b",
                   d_done, rdata, err, e.side, e.rdata, e.err);
        end
      end
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
    end
  end

  task automatic push_exp(input logic side, input logic [31:0] rd, input logic er);
    exp_t e;
    e.side = side; e.rdata = rd; e.err = er;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wait_done: %0d completions still pending after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, i_done, d_done, err} !== 5'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b we=%0b addr=%h wdata=%h rdata=%h err=%0b, required all zero",
               mem_req, mem_we, mem_addr, mem_wdata, rdata, err);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tie;
    ack_delay = 1; mem_rdata = 32'h1111_2222;
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    push_exp(1'b0, 32'h1111_2222, 1'b0);
    push_exp(1'b1, 32'h1111_2222, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL tie_first_grant: req=%0b addr=%h, required req=1 addr=00000100", mem_req, mem_addr);
    end
    wait_done(20);
    i_req = 1'b1; d_req = 1'b1;
    push_exp(1'b0, 32'h1111_2222, 1'b0);
    push_exp(1'b1, 32'h1111_2222, 1'b0);
    wait_done(20);
  endtask

  task automatic test_single_read;
    ack_delay = 3; mem_rdata = 32'h0050_0093;
    i_addr = 32'h0000_0040; i_req = 1'b1;
    push_exp(1'b0, 32'h0050_0093, 1'b0);
    #1;
    checks++;
    if (stallF !== 1'b1) begin
      errors++; $display("FAIL read_stall_c0: stallF=%0b, required 1", stallF);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0040 || mem_we !== 1'b0 || stallF !== 1'b1) begin
        errors++;
        $display("FAIL read_busy_c%0d: req=%0b addr=%h we=%0b stallF=%0b, required 1/00000040/0/1",
                 c, mem_req, mem_addr, mem_we, stallF);
      end
    end
    @(negedge clk);
    checks++;
    if (i_done !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL read_done_c4: i_done=%0b mem_req=%0b, required 1/0", i_done, mem_req);
    end
    @(negedge clk);
    checks++;
    if (i_done !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL read_idle_c5: i_done=%0b mem_req=%0b, required 0/0", i_done, mem_req);
    end
  endtask

  task automatic test_store;
    ack_delay = 4; mem_rdata = 32'hCAFE_F00D;
    d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1; d_req = 1'b1;
    push_exp(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    d_wdata = 32'h1234_5678; d_addr = 32'h0000_9999;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h0000_1000) begin
        errors++;
        $display("FAIL store_hold: req=%0b we=%0b wdata=%h addr=%h, required 1/1/deadbeef/00001000",
                 mem_req, mem_we, mem_wdata, mem_addr);
      end
      @(negedge clk);
    end
    wait_done(10);
    d_we = 1'b0;
  endtask

  task automatic test_timeout;
    int hi = 0;
    ack_delay = 0; mem_rdata = 32'hFFFF_FFFF;
    i_addr = 32'h0000_0080; i_req = 1'b1;
    push_exp(1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_req) hi++;
    end
    checks++;
    if (hi != 16) begin
      errors++; $display("FAIL timeout_len: mem_req high %0d cycles, required 16", hi);
    end
    wait_done(5);
    ack_delay = 2; mem_rdata = 32'h0BAD_F00D;
    d_addr = 32'h0000_0300; d_req = 1'b1;
    push_exp(1'b1, 32'h0BAD_F00D, 1'b0);
    wait_done(10);
  endtask

  task automatic test_ack_last;
    ack_delay = 16; mem_rdata = 32'h5A5A_A5A5;
    i_addr = 32'h0000_00C0; i_req = 1'b1;
    push_exp(1'b0, 32'h5A5A_A5A5, 1'b0);
    wait_done(25);
  endtask

  task automatic test_reset_mid;
    ack_delay = 0;
    d_addr = 32'h0000_0400; d_we = 1'b0; d_req = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || d_done !== 1'b0 || stallM !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort: mem_req=%0b d_done=%0b stallM=%0b, required 0/0/1", mem_req, d_done, stallM);
    end
    @(negedge clk);
    @(negedge clk);
    ack_delay = 2; mem_rdata = 32'h7777_0001;
    push_exp(1'b1, 32'h7777_0001, 1'b0);
    reset = 1'b1;
    wait_done(10);
  endtask

  task automatic test_stray_ack;
    stray = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: mem_req=%0b i_done=%0b d_done=%0b, required 0/0/0", mem_req, i_done, d_done);
    end
    stray = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_tie;
    test_single_read;
    test_store;
    test_timeout;
    test_ack_last;
    test_reset_mid;
    test_stray_ack;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
